// File: rtl/cc_pkg.sv
// Shared types and constants for the cc_loader front-end.
package cc_pkg;

    localparam int unsigned DATA_W    = 4;
    localparam int unsigned OPT_W     = 3;
    localparam int unsigned N_SAMPLES = 4;

    // One assembled frame: opcode plus four samples in arrival order.
    typedef struct packed {
        logic [OPT_W-1:0]  opt;
        logic [DATA_W-1:0] n0;
        logic [DATA_W-1:0] n1;
        logic [DATA_W-1:0] n2;
        logic [DATA_W-1:0] n3;
    } frame_t;

    // Slot currently waiting to be filled.
    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        FILL3 = 2'd3
    } fill_state_e;

    // Slot that follows s after a transfer; FILL3 wraps back to FILL0.
    function automatic fill_state_e next_fill(input fill_state_e s);
        unique case (s)
            FILL0:   return FILL1;
            FILL1:   return FILL2;
            FILL2:   return FILL3;
            default: return FILL0;
        endcase
    endfunction

endpackage

// File: rtl/cc_frame_fifo.sv
// DEPTH-entry FIFO of frame_t. Head entry is always visible on o_head.
// The caller may push while full only if it pops in the same cycle.
module cc_frame_fifo
    import cc_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_push,
    input  frame_t i_data,
    input  logic   i_pop,
    output frame_t o_head,
    output logic   o_full,
    output logic   o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    frame_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_d;

    // Occupancy: push and pop together leave the count unchanged, even when full.
    always_comb begin
        w_count_d = r_count;
        unique case ({i_push, i_pop})
            2'b10:   w_count_d = r_count + CNT_W'(1);
            2'b01:   w_count_d = r_count - CNT_W'(1);
            default: w_count_d = r_count;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_d;
        end
    end

    // Frame storage, cleared on reset so an empty head reads as all zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/cc_loader.sv
// Serial sample loader: assembles four 4-bit samples plus an opcode into a
// frame, queues frames in cc_frame_fifo and presents the head frame downstream.
// Optional partial-frame timeout is enabled by defining CC_LOADER_TIMEOUT_EN.
module cc_loader
    import cc_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OPT_W-1:0]  in_opt,
    output logic              frm_valid,
    input  logic              frm_ready,
    output logic [DATA_W-1:0] frm_n0,
    output logic [DATA_W-1:0] frm_n1,
    output logic [DATA_W-1:0] frm_n2,
    output logic [DATA_W-1:0] frm_n3,
    output logic [OPT_W-1:0]  frm_opt,
    output logic              err
);

    // Parameter sanity, caught at elaboration.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cc_loader: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("cc_loader: TIMEOUT must be >= 1");
    end

    fill_state_e       r_state;
    fill_state_e       w_state_d;
    logic [OPT_W-1:0]  r_opt;
    logic [DATA_W-1:0] r_slot0;
    logic [DATA_W-1:0] r_slot1;
    logic [DATA_W-1:0] r_slot2;

    logic   w_xfer;
    logic   w_push;
    logic   w_pop;
    logic   w_full;
    logic   w_empty;
    logic   w_expire;
    frame_t w_frame;
    frame_t w_head;

    // Samples are opaque bit patterns here; sign handling belongs downstream.
    // frm_ready feeds in_ready combinationally so a full FIFO can push and pop at once.
    assign in_ready  = (r_state != FILL3) || !w_full || frm_ready;
    assign w_xfer    = in_valid && in_ready;
    assign w_push    = w_xfer && (r_state == FILL3);
    assign frm_valid = !w_empty;
    assign w_pop     = frm_valid && frm_ready;

    // Frame being pushed: captured slots plus the sample arriving this cycle.
    always_comb begin
        w_frame     = '0;
        w_frame.opt = r_opt;
        w_frame.n0  = r_slot0;
        w_frame.n1  = r_slot1;
        w_frame.n2  = r_slot2;
        w_frame.n3  = in_data;
    end

`ifdef CC_LOADER_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] r_idle;
    logic              r_err;

    // Expiry fires on the edge where the idle count would reach TIMEOUT; a transfer wins.
    assign w_expire = (r_state != FILL0) && !w_xfer && (r_idle == IDLE_W'(TIMEOUT - 1));

    // Idle counter: runs only while a partial frame is waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_xfer || (r_state == FILL0) || w_expire) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    // One-cycle drop indication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_expire;
    end

    assign err = r_err;
`else
    assign w_expire = 1'b0;
    assign err      = 1'b0;
`endif

    // Assembly FSM next state: advance on transfer, fall back to FILL0 on timeout.
    always_comb begin
        w_state_d = r_state;
        if (w_xfer) begin
            w_state_d = next_fill(r_state);
        end else if (w_expire) begin
            w_state_d = FILL0;
        end
    end

    // Assembly FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FILL0;
        else     r_state <= w_state_d;
    end

    // Slot capture; opcode is taken only with the first sample of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opt   <= '0;
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_slot2 <= '0;
        end else if (w_xfer) begin
            unique case (r_state)
                FILL0: begin
                    r_opt   <= in_opt;
                    r_slot0 <= in_data;
                end
                FILL1:   r_slot1 <= in_data;
                FILL2:   r_slot2 <= in_data;
                default: ;
            endcase
        end else if (w_expire) begin
            r_opt   <= '0;
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_slot2 <= '0;
        end
    end

    cc_frame_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_frame),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign frm_n0  = w_head.n0;
    assign frm_n1  = w_head.n1;
    assign frm_n2  = w_head.n2;
    assign frm_n3  = w_head.n3;
    assign frm_opt = w_head.opt;

endmodule

// File: tb/tb_cc_loader.sv
// Directed bench for cc_loader with a frame scoreboard.
// Timeout scenarios are exercised when CC_LOADER_TIMEOUT_EN is defined.
module tb_cc_loader;
    import cc_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [OPT_W-1:0]  in_opt;
    logic              frm_valid;
    logic              frm_ready;
    logic [DATA_W-1:0] frm_n0;
    logic [DATA_W-1:0] frm_n1;
    logic [DATA_W-1:0] frm_n2;
    logic [DATA_W-1:0] frm_n3;
    logic [OPT_W-1:0]  frm_opt;
    logic              err;

    int errors = 0;
    int checks = 0;

    // Scoreboard and assembly model.
    frame_t            exp_q [$];
    int                m_idx = 0;
    logic [OPT_W-1:0]  m_opt;
    logic [DATA_W-1:0] m_s0, m_s1, m_s2;

    cc_loader #(
        .DEPTH   (2),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_opt    (in_opt),
        .frm_valid (frm_valid),
        .frm_ready (frm_ready),
        .frm_n0    (frm_n0),
        .frm_n1    (frm_n1),
        .frm_n2    (frm_n2),
        .frm_n3    (frm_n3),
        .frm_opt   (frm_opt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_idx = 0;
    endtask

    // Record one accepted sample; the fourth completes an expected frame.
    task automatic model_accept(input logic [DATA_W-1:0] d, input logic [OPT_W-1:0] o);
        frame_t f;
        case (m_idx)
            0: begin m_opt = o; m_s0 = d; end
            1: m_s1 = d;
            2: m_s2 = d;
            default: begin
                f.opt = m_opt; f.n0 = m_s0; f.n1 = m_s1; f.n2 = m_s2; f.n3 = d;
                exp_q.push_back(f);
            end
        endcase
        m_idx = (m_idx + 1) % 4;
    endtask

    // Offer one sample and wait (bounded) until it is accepted.
    task automatic send(input logic [DATA_W-1:0] d, input logic [OPT_W-1:0] o);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_opt   = o;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accepted", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_accept(d, o);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && frm_valid && frm_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'd1, 32'd0);
            end else begin
                chk("pop_opt", {29'b0, frm_opt}, {29'b0, exp_q[0].opt});
                chk("pop_n0", {28'b0, frm_n0}, {28'b0, exp_q[0].n0});
                chk("pop_n1", {28'b0, frm_n1}, {28'b0, exp_q[0].n1});
                chk("pop_n2", {28'b0, frm_n2}, {28'b0, exp_q[0].n2});
                chk("pop_n3", {28'b0, frm_n3}, {28'b0, exp_q[0].n3});
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_opt    = '0;
        frm_ready = 1'b0;
        idle(3);

        // Reset state
        chk("rst_frm_valid", {31'b0, frm_valid}, 32'd0);
        chk("rst_n0", {28'b0, frm_n0}, 32'd0);
        chk("rst_n1", {28'b0, frm_n1}, 32'd0);
        chk("rst_n2", {28'b0, frm_n2}, 32'd0);
        chk("rst_n3", {28'b0, frm_n3}, 32'd0);
        chk("rst_opt", {29'b0, frm_opt}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Basic frame: 3, -2, 7, -8 with opt 5; visible right after the 4th sample
        frm_ready = 1'b1;
        send(4'h3, 3'd5);
        send(4'hE, 3'd5);
        send(4'h7, 3'd5);
        send(4'h8, 3'd5);
        chk("lat_valid", {31'b0, frm_valid}, 32'd1);
        chk("lat_n0", {28'b0, frm_n0}, 32'h3);
        chk("lat_n1", {28'b0, frm_n1}, 32'hE);
        chk("lat_n2", {28'b0, frm_n2}, 32'h7);
        chk("lat_n3", {28'b0, frm_n3}, 32'h8);
        chk("lat_opt", {29'b0, frm_opt}, 32'd5);
        idle(1);
        chk("lat_popped", {31'b0, frm_valid}, 32'd0);

        // Back-pressure: two frames queue, third stalls in FILL3
        frm_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'(i + 1), 3'd1);
        for (int i = 0; i < 4; i++) send(4'(i + 9), 3'd3);
        for (int i = 0; i < 3; i++) send(4'(15 - i), 3'd4);
        in_valid = 1'b1;
        in_data  = 4'h5;
        in_opt   = 3'd4;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        end
        chk("full_frm_valid", {31'b0, frm_valid}, 32'd1);
        // Raise frm_ready: push and pop land on the same edge while full
        @(posedge clk);
        #1;
        frm_ready = 1'b1;
        @(negedge clk);
        chk("full_comb_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_accept(4'h5, 3'd4);
        chk("full_still_valid", {31'b0, frm_valid}, 32'd1);
        idle(4);
        chk("drain_empty", {31'b0, frm_valid}, 32'd0);
        chk("drain_sb_empty", exp_q.size(), 32'd0);

        // opt on samples 2-4 is ignored
        send(4'h1, 3'd2);
        send(4'h2, 3'd1);
        send(4'h3, 3'd6);
        send(4'h4, 3'd7);
        chk("opt_first", {29'b0, frm_opt}, 32'd2);
        idle(2);

        // Reset with one frame queued and a partial frame in progress
        frm_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'(i + 6), 3'd0);
        send(4'hA, 3'd7);
        send(4'hB, 3'd7);
        chk("pre_rst_valid", {31'b0, frm_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'b0, frm_valid}, 32'd0);
        chk("rst_async_ready", {31'b0, in_ready}, 32'd1);
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        frm_ready = 1'b1;
        send(4'hC, 3'd3);
        send(4'hD, 3'd3);
        send(4'h0, 3'd3);
        send(4'h9, 3'd3);
        chk("post_rst_n0", {28'b0, frm_n0}, 32'hC);
        idle(2);
        chk("post_rst_sb_empty", exp_q.size(), 32'd0);

`ifdef CC_LOADER_TIMEOUT_EN
        // Partial frame dropped after 15 idle cycles
        send(4'h1, 3'd1);
        send(4'h2, 3'd1);
        repeat (14) @(posedge clk);
        #1;
        chk("to_no_err_early", {31'b0, err}, 32'd0);
        @(posedge clk);
        #1;
        chk("to_err_pulse", {31'b0, err}, 32'd1);
        @(posedge clk);
        #1;
        chk("to_err_one_cycle", {31'b0, err}, 32'd0);
        model_clear();
        send(4'h4, 3'd6);
        send(4'h5, 3'd6);
        send(4'h6, 3'd6);
        send(4'h7, 3'd6);
        idle(2);
        chk("to_sb_empty", exp_q.size(), 32'd0);

        // Sample on the 15th idle cycle rescues the partial frame
        send(4'h8, 3'd2);
        send(4'h9, 3'd2);
        repeat (14) @(posedge clk);
        #1;
        send(4'hA, 3'd2);
        chk("rescue_no_err", {31'b0, err}, 32'd0);
        idle(3);
        chk("rescue_no_err_late", {31'b0, err}, 32'd0);
        send(4'hB, 3'd2);
        idle(2);
        chk("rescue_sb_empty", exp_q.size(), 32'd0);
`else
        // Without the timeout, a partial frame waits indefinitely
        send(4'h1, 3'd1);
        send(4'h2, 3'd1);
        idle(30);
        chk("nto_err_low", {31'b0, err}, 32'd0);
        chk("nto_no_frame", {31'b0, frm_valid}, 32'd0);
        send(4'h3, 3'd4);
        send(4'h4, 3'd4);
        chk("nto_frame_opt", {29'b0, frm_opt}, 32'd1);
        idle(2);
        chk("nto_sb_empty", exp_q.size(), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
